// File: rtl/rv32i_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// It alone advances architectural state: it gates the IR load, PC write, RF write and memory requests.
module rv32i_mc_sequencer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        cu_rdwrite,
    input  logic [1:0]  cu_rdtype,
    input  logic        cu_store,
    input  logic        cu_branch,
    input  logic        cu_PCtype,
    input  logic        branch_taken,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_load,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        rf_write,
    output logic [2:0]  state,
    output logic        halted,
    output logic        bus_err,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           cur;
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
    logic             mem_op;
    logic             retire;

    // The wait that would push the counter to MEM_TIMEOUT is the last one allowed.
    assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_LAST);
    assign mem_op    = cu_store | (cu_rdtype == 2'b01);

    always_ff @(posedge clock) begin
        if (reset) begin
            cur      <= S_IDLE;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
            instret  <= '0;
        end else begin
            case (cur)
                S_IDLE: begin
                    if (run) begin
                        cur      <= S_FETCH;
                        wait_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        cur <= S_DECODE;
                    end else if (timed_out) begin
                        cur     <= S_ERR;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: cur <= S_EXEC;
                S_EXEC: begin
                    if (mem_op) begin
                        cur      <= S_MEM;
                        wait_cnt <= '0;
                    end else begin
                        cur <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        cur <= S_WB;
                    end else if (timed_out) begin
                        cur     <= S_ERR;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    instret <= instret + 32'd1;
                    if (run) begin
                        cur      <= S_FETCH;
                        wait_cnt <= '0;
                    end else begin
                        cur <= S_IDLE;
                    end
                end
                S_ERR:   cur <= S_ERR;
                default: cur <= S_IDLE;
            endcase
        end
    end

    // An instruction caught by reset in WB is aborted, so its writes are suppressed too.
    assign retire   = (cur == S_WB) & ~reset;

    assign state    = cur;
    assign halted   = (cur == S_IDLE);
    assign imem_req = (cur == S_FETCH);
    assign ir_load  = imem_req & imem_ack;
    assign dmem_req = (cur == S_MEM);
    assign dmem_we  = dmem_req & cu_store;
    assign pc_write = retire;
    assign pc_sel   = retire & (cu_PCtype | (cu_branch & branch_taken));
    assign rf_write = retire & cu_rdwrite;

endmodule

// File: tb/tb_rv32i_mc_sequencer.sv
// Directed bench for rv32i_mc_sequencer: per-cycle expected outputs are queued with the
// stimulus, then popped and checked at the falling edge of each cycle.
module tb_rv32i_mc_sequencer;

    logic        clock = 1'b0;
    logic        reset, run, cu_rdwrite, cu_store, cu_branch, cu_PCtype, branch_taken;
    logic [1:0]  cu_rdtype;
    logic        imem_ack, dmem_ack;
    logic        imem_req, dmem_req, dmem_we, ir_load, pc_write, pc_sel, rf_write;
    logic [2:0]  state;
    logic        halted, bus_err;
    logic [31:0] instret;

    rv32i_mc_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .run(run),
        .cu_rdwrite(cu_rdwrite), .cu_rdtype(cu_rdtype), .cu_store(cu_store),
        .cu_branch(cu_branch), .cu_PCtype(cu_PCtype), .branch_taken(branch_taken),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel), .rf_write(rf_write),
        .state(state), .halted(halted), .bus_err(bus_err), .instret(instret)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        rst;
        logic        run;
        logic        ia;
        logic        da;
        logic [11:0] exp;
    } step_t;

    step_t step_q[$];
    string tag_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    // {state, halted, imem_req, ir_load, dmem_req, dmem_we, pc_write, pc_sel, rf_write, bus_err}
    function automatic logic [11:0] exp_o(input logic [2:0] st, input logic ireq, input logic ir,
                                          input logic dreq, input logic dwe, input logic pcw,
                                          input logic pcs, input logic rfw, input logic berr);
        return {st, (st == 3'd0), ireq, ir, dreq, dwe, pcw, pcs, rfw, berr};
    endfunction

    task automatic push(input string tag, input logic rst_v, input logic run_v,
                        input logic ia_v, input logic da_v, input logic [11:0] e);
        step_t s;
        s.rst = rst_v; s.run = run_v; s.ia = ia_v; s.da = da_v; s.exp = e;
        step_q.push_back(s);
        tag_q.push_back(tag);
    endtask

    task automatic set_cu(input logic rdw, input logic [1:0] rdt, input logic st,
                          input logic br, input logic pct, input logic bt);
        cu_rdwrite = rdw; cu_rdtype = rdt; cu_store = st;
        cu_branch = br; cu_PCtype = pct; branch_taken = bt;
    endtask

    // Called just after a rising edge; each popped step occupies one clock cycle.
    task automatic flush();
        step_t       s;
        string       t;
        logic [11:0] obs;
        while (step_q.size() > 0) begin
            s = step_q.pop_front();
            t = tag_q.pop_front();
            reset = s.rst; run = s.run; imem_ack = s.ia; dmem_ack = s.da;
            @(negedge clock);
            obs = {state, halted, imem_req, ir_load, dmem_req, dmem_we,
                   pc_write, pc_sel, rf_write, bus_err};
            n_cmp++;
            assert (obs === s.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %03h expected %03h", t, obs, s.exp);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk_instret(input string tag, input logic [31:0] e);
        n_cmp++;
        assert (instret === e) else begin
            n_fail++;
            $error("FAIL %s: observed instret %0d expected %0d", tag, instret, e);
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        set_cu(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;

        // Reset state, then reset in MEM of a load
        push("reset_state", 1, 0, 0, 0, exp_o(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        push("idle_go",     0, 1, 0, 0, exp_o(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        flush();
        chk_instret("instret_reset", 32'd0);
        set_cu(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        push("rst_lw_fetch", 0, 1, 1, 0, exp_o(3'd1, 1, 1, 0, 0, 0, 0, 0, 0));
        push("rst_lw_dec",   0, 1, 0, 0, exp_o(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
        push("rst_lw_exec",  0, 1, 0, 0, exp_o(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
        push("rst_lw_mem",   1, 1, 0, 0, exp_o(3'd4, 0, 0, 1, 0, 0, 0, 0, 0));
        push("rst_to_idle",  0, 0, 0, 0, exp_o(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        flush();
        chk_instret("instret_after_abort", 32'd0);

        // ADDI, zero-wait; stray dmem_ack in EXEC must be ignored
        push("addi_idle", 0, 1, 0, 0, exp_o(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        flush();
        set_cu(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        push("addi_fetch", 0, 1, 1, 0, exp_o(3'd1, 1, 1, 0, 0, 0, 0, 0, 0));
        push("addi_dec",   0, 1, 0, 0, exp_o(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
        push("addi_exec",  0, 1, 0, 1, exp_o(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
        push("addi_wb",    0, 1, 0, 0, exp_o(3'd5, 0, 0, 0, 0, 1, 0, 1, 0));
        flush();
        chk_instret("instret_addi", 32'd1);

        // LW with dmem_ack 3 cycles late (ack on the last permitted wait cycle)
        set_cu(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        push("lw_fetch", 0, 1, 1, 0, exp_o(3'd1, 1, 1, 0, 0, 0, 0, 0, 0));
        push("lw_dec",   0, 1, 1, 0, exp_o(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
        push("lw_exec",  0, 1, 0, 1, exp_o(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            push("lw_mem_wait", 0, 1, 0, 0, exp_o(3'd4, 0, 0, 1, 0, 0, 0, 0, 0));
        push("lw_mem_ack", 0, 1, 0, 1, exp_o(3'd4, 0, 0, 1, 0, 0, 0, 0, 0));
        push("lw_wb",      0, 1, 0, 0, exp_o(3'd5, 0, 0, 0, 0, 1, 0, 1, 0));
        flush();
        chk_instret("instret_lw", 32'd2);

        // SW
        set_cu(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        push("sw_fetch", 0, 1, 1, 0, exp_o(3'd1, 1, 1, 0, 0, 0, 0, 0, 0));
        push("sw_dec",   0, 1, 0, 0, exp_o(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
        push("sw_exec",  0, 1, 0, 0, exp_o(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
        push("sw_mem",   0, 1, 0, 1, exp_o(3'd4, 0, 0, 1, 1, 0, 0, 0, 0));
        push("sw_wb",    0, 1, 0, 0, exp_o(3'd5, 0, 0, 0, 0, 1, 0, 0, 0));
        flush();
        chk_instret("instret_sw", 32'd3);

        // BEQ taken
        set_cu(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        push("beq_fetch", 0, 1, 1, 0, exp_o(3'd1, 1, 1, 0, 0, 0, 0, 0, 0));
        push("beq_dec",   0, 1, 0, 0, exp_o(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
        push("beq_exec",  0, 1, 0, 0, exp_o(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
        push("beq_wb",    0, 1, 0, 0, exp_o(3'd5, 0, 0, 0, 0, 1, 1, 0, 0));
        flush();
        chk_instret("instret_beq", 32'd4);

        // BNE not taken, imem_ack 2 cycles late
        set_cu(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        push("bne_fetch_wait", 0, 1, 0, 0, exp_o(3'd1, 1, 0, 0, 0, 0, 0, 0, 0));
        push("bne_fetch_wait", 0, 1, 0, 0, exp_o(3'd1, 1, 0, 0, 0, 0, 0, 0, 0));
        push("bne_fetch_ack",  0, 1, 1, 0, exp_o(3'd1, 1, 1, 0, 0, 0, 0, 0, 0));
        push("bne_dec",        0, 1, 0, 0, exp_o(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
        push("bne_exec",       0, 1, 0, 0, exp_o(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
        push("bne_wb",         0, 1, 0, 0, exp_o(3'd5, 0, 0, 0, 0, 1, 0, 0, 0));
        flush();
        chk_instret("instret_bne", 32'd5);

        // JAL with run dropped in EXEC: retires, then halts
        set_cu(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
        push("jal_fetch", 0, 1, 1, 0, exp_o(3'd1, 1, 1, 0, 0, 0, 0, 0, 0));
        push("jal_dec",   0, 1, 0, 0, exp_o(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
        push("jal_exec",  0, 0, 0, 0, exp_o(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
        push("jal_wb",    0, 0, 0, 0, exp_o(3'd5, 0, 0, 0, 0, 1, 1, 1, 0));
        push("jal_idle",  0, 0, 0, 0, exp_o(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        push("jal_idle2", 0, 0, 1, 1, exp_o(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        flush();
        chk_instret("instret_jal", 32'd6);

        // Fetch timeout: 4 waits, then sticky ERR until reset
        set_cu(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        push("to_idle", 0, 1, 0, 0, exp_o(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            push("to_fetch_wait", 0, 1, 0, 0, exp_o(3'd1, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            push("to_err_hold", 0, 1, 1, 1, exp_o(3'd6, 0, 0, 0, 0, 0, 0, 0, 1));
        push("to_err_reset", 1, 1, 0, 0, exp_o(3'd6, 0, 0, 0, 0, 0, 0, 0, 1));
        push("to_after_rst", 0, 1, 0, 0, exp_o(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        flush();
        chk_instret("instret_after_err_reset", 32'd0);

        // Ack on the 4th wait cycle wins over the timeout
        for (int i = 0; i < 3; i++)
            push("race_fetch_wait", 0, 1, 0, 0, exp_o(3'd1, 1, 0, 0, 0, 0, 0, 0, 0));
        push("race_fetch_ack", 0, 1, 1, 0, exp_o(3'd1, 1, 1, 0, 0, 0, 0, 0, 0));
        push("race_dec",       0, 1, 0, 0, exp_o(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
        push("race_exec",      0, 1, 0, 0, exp_o(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
        push("race_wb",        0, 0, 0, 0, exp_o(3'd5, 0, 0, 0, 0, 1, 0, 1, 0));
        push("race_idle",      0, 0, 0, 0, exp_o(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        flush();
        chk_instret("instret_race", 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_mc_sequencer.md
# rv32i_mc_sequencer

Multi-cycle sequencer for the RV32I core. Steps each instruction through fetch, decode, execute, memory and write-back, and drives the instruction/data memory request handshakes. Gates the IR load, PC write and register-file write enables using the decoded control signals from the control unit. It is the only block that may advance architectural state (PC, register file, memory).

## Interface
- MEM_TIMEOUT, 255: wait cycles allowed for a memory ack before a bus error; 0 disables the timeout.
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  1 = execute instructions; 0 = stop at the next instruction boundary
- cu_rdwrite  in  1  rd write enable from the control unit
- cu_rdtype  in  2  rd source from the control unit; 2'b01 = load
- cu_store  in  1  store instruction
- cu_branch  in  1  branch/jump instruction
- cu_PCtype  in  1  1 = unconditional PC redirect (JAL/JALR)
- branch_taken  in  1  branch comparator result, valid in EXEC and WB
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; meaningful only while dmem_req = 1
- ir_load  out  1  capture the instruction word into IR
- pc_write  out  1  update PC
- pc_sel  out  1  0 = PC+4, 1 = ALU target
- rf_write  out  1  register-file write strobe
- state  out  3  current state encoding
- halted  out  1  1 while in IDLE
- bus_err  out  1  sticky memory timeout flag
- instret  out  32  retired-instruction counter

## Operation
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, ERR = 6. Codes 7 and above go to IDLE.
- Output decode:
  - Outputs are decoded from the registered state plus current inputs; there are no output registers other than state, the timeout counter, bus_err and instret.
  - Every output is 0 outside the states listed below.
- IDLE:
  - halted = 1.
  - run = 1 → FETCH.
- FETCH:
  - imem_req = 1.
  - On imem_ack: ir_load = 1 in the same cycle, then → DECODE.
- DECODE: single cycle while control-unit outputs settle from IR → EXEC.
- EXEC: mem_op = cu_store | (cu_rdtype == 2'b01).
  - mem_op = 1 → MEM.
  - mem_op = 0 → WB.
- MEM:
  - dmem_req = 1, dmem_we = cu_store.
  - On dmem_ack → WB.
- WB:
  - pc_write = 1.
  - pc_sel = cu_PCtype | (cu_branch & branch_taken).
  - rf_write = cu_rdwrite.
  - instret increments by 1.
  - Next state: run ? FETCH : IDLE.
- Timeout counter:
  - Width is ceil(log2(MEM_TIMEOUT+1)).
  - Cleared on every entry to FETCH or MEM; increments each cycle spent waiting there without an ack.
  - Reaching MEM_TIMEOUT with no ack → ERR, and bus_err is set.
- ERR:
  - All requests and enables are 0; bus_err = 1.
  - Remains in ERR until reset.
- instret wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values: state = IDLE, halted = 1, bus_err = 0, instret = 0, timeout counter = 0. All other outputs are 0.
- Latency with ack in the same cycle as the request:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each cycle the ack is late adds one cycle.
- Handshake:
  - A request stays high until the cycle in which its ack is sampled high. It drops the next cycle.
  - An ack outside FETCH/MEM is ignored.
- Simultaneous events:
  - If the ack arrives in the cycle the counter reaches MEM_TIMEOUT, the ack wins: no error is raised.
- run:
  - Sampled only in IDLE and WB.
  - Deasserting run mid-instruction lets the instruction complete and retire.
- Reset:
  - Reset mid-operation (including in MEM with dmem_req high) returns to IDLE in the next cycle.
  - Requests drop; no pc_write or rf_write is issued for the aborted instruction; instret is not incremented.
- pc_write and rf_write are each asserted for exactly one cycle per retired instruction.

## Test plan
- ADDI, zero-wait memories:
  - Stimulus: reset, then run = 1.
  - Required: state sequence 1, 2, 3, 5, 1. Single-cycle pulses of ir_load, pc_write and rf_write. pc_sel = 0. instret = 1 after WB.
- LW with dmem_ack delayed 3 cycles:
  - Required: dmem_req high for 4 cycles with dmem_we = 0, then WB with rf_write = 1. Total instruction latency 8 cycles.
- SW, then a taken BEQ (branch_taken = 1), then a not-taken BNE:
  - Required: dmem_we = 1 and rf_write = 0 for SW. pc_sel = 1 for the taken BEQ, 0 for the BNE. instret = 3.
- MEM_TIMEOUT = 4, imem_ack held low:
  - Required: FETCH lasts 4 wait cycles, then ERR with bus_err = 1 and imem_req = 0. Stays in ERR until reset.
  - Second case: imem_ack arriving exactly on the 4th wait cycle → DECODE, bus_err = 0.
- run dropped during EXEC of JAL:
  - Required: MEM skipped; WB issues pc_sel = 1, rf_write = 1; then IDLE with halted = 1.
  - Reset asserted during MEM: IDLE next cycle, dmem_req = 0, instret unchanged.
